// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   RV32 instruction fetch stage. Issues one instruction-memory request at a
//   time over a valid/ready pair. It waits for the response and holds the
//   fetched word on the F_* outputs until decode accepts it. A static
//   predictor chooses the next fetch address. Execute can flush the unit and
//   restart fetch from a new PC.
//
//   Ports
//     clk, rst          clock; asynchronous active-high reset
//     Inst_Req_Valid    request valid (registered)
//     Inst_Req_Ready    memory accepts the request
//     PC                request address, word aligned, stable until accepted
//     Instruction       response word
//     Inst_Valid        response valid
//     Inst_Ready        unit can take a response (high only while waiting)
//     redirect_valid    flush and refetch from redirect_pc
//     redirect_pc       new PC, low two bits forced to zero
//     F_valid           F_* outputs hold an instruction for decode
//     F_ready           decode accepts the held instruction
//     F_PC, F_instr     PC and word of the held instruction
//     F_BranchTaken     the fetch after this one follows a predicted-taken target
//     F_recoverPC       PC to resume at if that prediction turns out wrong
// -----------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter bit          PREDICT_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        Inst_Req_Valid,
   input  logic        Inst_Req_Ready,
   output logic [31:0] PC,
   input  logic [31:0] Instruction,
   input  logic        Inst_Valid,
   output logic        Inst_Ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        F_valid,
   input  logic        F_ready,
   output logic [31:0] F_PC,
   output logic [31:0] F_instr,
   output logic        F_BranchTaken,
   output logic [31:0] F_recoverPC
);

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;         // address of the current / next fetch
   logic        drop_q;       // the outstanding response belongs to a flushed fetch
   logic        req_valid_q;
   logic [31:0] req_pc_q;
   logic        inst_ready_q;
   logic        f_valid_q;
   logic [31:0] f_pc_q;
   logic [31:0] f_instr_q;
   logic        f_taken_q;
   logic [31:0] f_recover_q;
   logic [31:0] next_pc_q;    // predicted successor of the held instruction

   logic [31:0] redir_pc;
   logic [31:0] imm_j;
   logic [31:0] imm_b;
   logic [31:0] seq_pc;
   logic [31:0] pred_next_d;
   logic        pred_taken_d;
   logic [31:0] pred_recover_d;

   // Masking keeps every redirect bit in the expression; the result is word aligned.
   assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

   // The prediction is evaluated on the incoming response word and its fetch
   // address, then registered together with F_instr/F_PC. The F_* outputs
   // therefore stay constant while held and read zero out of reset.
   assign imm_j  = {{12{Instruction[31]}}, Instruction[19:12], Instruction[20],
                    Instruction[30:21], 1'b0};
   assign imm_b  = {{20{Instruction[31]}}, Instruction[7], Instruction[30:25],
                    Instruction[11:8], 1'b0};
   assign seq_pc = pc_q + 32'd4;

   always_comb begin
      pred_next_d    = seq_pc;
      pred_taken_d   = 1'b0;
      pred_recover_d = seq_pc;
      if (Instruction[6:0] == OP_JAL) begin
         if (PREDICT_EN) begin
            pred_next_d  = pc_q + imm_j;
            pred_taken_d = 1'b1;
         end
      end else if (Instruction[6:0] == OP_BRANCH) begin
         if (imm_b[31]) begin
            // Backward branch: assumed to close a loop, predict taken.
            if (PREDICT_EN) begin
               pred_next_d  = pc_q + imm_b;
               pred_taken_d = 1'b1;
            end
         end else begin
            // Forward branch: fall through, remember the target for recovery.
            pred_recover_d = pc_q + imm_b;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         drop_q       <= 1'b0;
         req_valid_q  <= 1'b0;
         req_pc_q     <= 32'h0;
         inst_ready_q <= 1'b0;
         f_valid_q    <= 1'b0;
         f_pc_q       <= 32'h0;
         f_instr_q    <= 32'h0;
         f_taken_q    <= 1'b0;
         f_recover_q  <= 32'h0;
         next_pc_q    <= 32'h0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q     <= S_REQ;
               req_valid_q <= 1'b1;
               req_pc_q    <= pc_q;
            end

            S_REQ: begin
               if (redirect_valid) begin
                  pc_q <= redir_pc;
                  if (Inst_Req_Ready) begin
                     // The old address was accepted this cycle; its response
                     // must still be consumed, then thrown away.
                     drop_q       <= 1'b1;
                     state_q      <= S_WAIT;
                     req_valid_q  <= 1'b0;
                     inst_ready_q <= 1'b1;
                  end else begin
                     req_pc_q <= redir_pc;
                  end
               end else if (Inst_Req_Ready) begin
                  state_q      <= S_WAIT;
                  req_valid_q  <= 1'b0;
                  inst_ready_q <= 1'b1;
               end
            end

            S_WAIT: begin
               if (redirect_valid) begin
                  pc_q <= redir_pc;
                  if (Inst_Valid) begin
                     drop_q       <= 1'b0;
                     state_q      <= S_REQ;
                     inst_ready_q <= 1'b0;
                     req_valid_q  <= 1'b1;
                     req_pc_q     <= redir_pc;
                  end else begin
                     drop_q <= 1'b1;
                  end
               end else if (Inst_Valid) begin
                  inst_ready_q <= 1'b0;
                  if (drop_q) begin
                     drop_q      <= 1'b0;
                     state_q     <= S_REQ;
                     req_valid_q <= 1'b1;
                     req_pc_q    <= pc_q;
                  end else begin
                     state_q     <= S_HOLD;
                     f_valid_q   <= 1'b1;
                     f_pc_q      <= pc_q;
                     f_instr_q   <= Instruction;
                     f_taken_q   <= pred_taken_d;
                     f_recover_q <= pred_recover_d;
                     next_pc_q   <= pred_next_d;
                  end
               end
            end

            S_HOLD: begin
               if (redirect_valid) begin
                  // A same-cycle F_ready handshake still completes; decode
                  // squashes that instruction on the redirect.
                  pc_q        <= redir_pc;
                  f_valid_q   <= 1'b0;
                  state_q     <= S_REQ;
                  req_valid_q <= 1'b1;
                  req_pc_q    <= redir_pc;
               end else if (F_ready) begin
                  pc_q        <= next_pc_q;
                  f_valid_q   <= 1'b0;
                  state_q     <= S_REQ;
                  req_valid_q <= 1'b1;
                  req_pc_q    <= next_pc_q;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign Inst_Req_Valid = req_valid_q;
   assign PC             = req_pc_q;
   assign Inst_Ready     = inst_ready_q;
   assign F_valid        = f_valid_q;
   assign F_PC           = f_pc_q;
   assign F_instr        = f_instr_q;
   assign F_BranchTaken  = f_taken_q;
   assign F_recoverPC    = f_recover_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed bench for if_fetch_unit (RESET_PC=0x100, prediction enabled).
//   A behavioural instruction memory answers requests with configurable
//   request stalls and response delays. The stimulus pushes the expected
//   request addresses and F_* transactions into queues. A monitor compares
//   them against what the DUT presents.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        taken;
      logic [31:0] rec;
   } fexp_t;

   logic        clk;
   logic        rst;
   logic        Inst_Req_Valid;
   logic        Inst_Req_Ready;
   logic [31:0] PC;
   logic [31:0] Instruction;
   logic        Inst_Valid;
   logic        Inst_Ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        F_valid;
   logic        F_ready;
   logic [31:0] F_PC;
   logic [31:0] F_instr;
   logic        F_BranchTaken;
   logic [31:0] F_recoverPC;

   int errors = 0;
   int checks = 0;

   logic [31:0] req_q[$];
   fexp_t       f_q[$];

   // memory model state and knobs
   logic [31:0] mem [logic [31:0]];
   logic [31:0] stall_addr = 32'hFFFF_FFF0;
   int          stall_left = 0;
   logic [31:0] slow_addr  = 32'hFFFF_FFF0;
   int          slow_delay = 0;

   if_fetch_unit #(
      .RESET_PC   (32'h0000_0100),
      .PREDICT_EN (1'b1)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .Inst_Req_Valid (Inst_Req_Valid),
      .Inst_Req_Ready (Inst_Req_Ready),
      .PC             (PC),
      .Instruction    (Instruction),
      .Inst_Valid     (Inst_Valid),
      .Inst_Ready     (Inst_Ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .F_valid        (F_valid),
      .F_ready        (F_ready),
      .F_PC           (F_PC),
      .F_instr        (F_instr),
      .F_BranchTaken  (F_BranchTaken),
      .F_recoverPC    (F_recoverPC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return NOP;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, got, exp);
      end
   endtask

   task automatic push_f(input logic [31:0] pc, input logic [31:0] instr,
                         input logic taken, input logic [31:0] rec);
      fexp_t e;
      e.pc = pc; e.instr = instr; e.taken = taken; e.rec = rec;
      f_q.push_back(e);
   endtask

   // Returns on the falling edge where F_valid shows the given PC.
   task automatic wait_f(input logic [31:0] pc);
      int n = 0;
      bit hit = 1'b0;
      while (!hit && n < 300) begin
         @(negedge clk);
         if (F_valid && F_PC == pc) hit = 1'b1;
         n++;
      end
      if (!hit) begin
         checks++; errors++;
         $display("FAIL timeout_f: F_PC %h never presented", pc);
      end
   endtask

   task automatic wait_ir();
      int n = 0;
      bit hit = 1'b0;
      while (!hit && n < 100) begin
         @(negedge clk);
         if (Inst_Ready) hit = 1'b1;
         n++;
      end
      if (!hit) begin
         checks++; errors++;
         $display("FAIL timeout_inst_ready: unit never entered wait");
      end
   endtask

   task automatic redirect(input logic [31:0] pc);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      @(negedge clk);
      redirect_valid = 1'b0;
   endtask

   // ---------------- instruction memory model ----------------
   initial begin : memory
      bit          pending;
      logic [31:0] pend_addr;
      int          cnt;
      bit          stall_now, acc, rsp;
      logic [31:0] acc_pc;
      pending = 1'b0; pend_addr = 32'h0; cnt = 0;
      Inst_Req_Ready = 1'b0;
      Inst_Valid     = 1'b0;
      Instruction    = 32'h0;
      forever begin
         @(negedge clk);
         stall_now      = Inst_Req_Valid && PC == stall_addr && stall_left > 0;
         Inst_Req_Ready = !stall_now;
         Inst_Valid     = pending && cnt == 0;
         Instruction    = pending ? mem_rd(pend_addr) : 32'h0;
         acc    = Inst_Req_Valid && Inst_Req_Ready;
         rsp    = Inst_Valid && Inst_Ready;
         acc_pc = PC;
         @(posedge clk);
         if (rst) begin
            pending = 1'b0;
         end else begin
            if (stall_now) stall_left--;
            if (rsp) pending = 1'b0;
            else if (pending && cnt > 0) cnt--;
            if (acc) begin
               pending   = 1'b1;
               pend_addr = acc_pc;
               cnt       = (acc_pc == slow_addr) ? slow_delay : 0;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      bit    fv_prev, hs_prev;
      fexp_t snap, e;
      fv_prev = 1'b0; hs_prev = 1'b0;
      snap = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            fv_prev = 1'b0;
            hs_prev = 1'b0;
         end else begin
            if (Inst_Req_Valid) begin
               checks++;
               if (req_q.size() == 0) begin
                  errors++;
                  $display("FAIL req_unexpected: request at PC=%h, none expected", PC);
               end else begin
                  if (PC !== req_q[0]) begin
                     errors++;
                     $display("FAIL req_pc: got %h, want %h", PC, req_q[0]);
                  end
                  if (Inst_Req_Ready) begin
                     $display("request pc=%h accepted", PC);
                     void'(req_q.pop_front());
                  end
               end
            end
            if (F_valid) begin
               checks++;
               if (Inst_Req_Valid || Inst_Ready) begin
                  errors++;
                  $display("FAIL hold_quiet: req_valid=%0d inst_ready=%0d while holding, want 0 0",
                           Inst_Req_Valid, Inst_Ready);
               end
               checks++;
               if (!fv_prev) begin
                  if (f_q.size() == 0) begin
                     errors++;
                     $display("FAIL f_unexpected: pc=%h instr=%h, none expected", F_PC, F_instr);
                  end else begin
                     e = f_q.pop_front();
                     if (F_PC !== e.pc || F_instr !== e.instr ||
                         F_BranchTaken !== e.taken || F_recoverPC !== e.rec) begin
                        errors++;
                        $display("FAIL f_out: got pc=%h instr=%h taken=%0d rec=%h, want pc=%h instr=%h taken=%0d rec=%h",
                                 F_PC, F_instr, F_BranchTaken, F_recoverPC,
                                 e.pc, e.instr, e.taken, e.rec);
                     end else begin
                        $display("fetch pc=%h instr=%h taken=%0d recover=%h",
                                 F_PC, F_instr, F_BranchTaken, F_recoverPC);
                     end
                  end
                  snap.pc = F_PC; snap.instr = F_instr;
                  snap.taken = F_BranchTaken; snap.rec = F_recoverPC;
               end else if (hs_prev) begin
                  errors++;
                  $display("FAIL f_after_accept: F_valid still 1 after handshake, want 0");
               end else if (F_PC !== snap.pc || F_instr !== snap.instr ||
                            F_BranchTaken !== snap.taken || F_recoverPC !== snap.rec) begin
                  errors++;
                  $display("FAIL f_stable: got pc=%h instr=%h, want pc=%h instr=%h",
                           F_PC, F_instr, snap.pc, snap.instr);
               end
            end
            fv_prev = F_valid;
            hs_prev = F_valid && F_ready;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin : stimulus
      rst = 1'b1;
      F_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_valid", {31'h0, Inst_Req_Valid}, 32'h0);
      chk("rst_pc", PC, 32'h0);
      chk("rst_fvalid", {31'h0, F_valid}, 32'h0);
      chk("rst_frecover", F_recoverPC, 32'h0);

      // 1: sequential nops from RESET_PC
      req_q.push_back(32'h100); req_q.push_back(32'h104); req_q.push_back(32'h108);
      push_f(32'h100, NOP, 1'b0, 32'h104);
      push_f(32'h104, NOP, 1'b0, 32'h108);
      push_f(32'h108, NOP, 1'b0, 32'h10C);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("req_valid_before_edge", {31'h0, Inst_Req_Valid}, 32'h0);
      @(posedge clk);
      #1;
      chk("req_valid_after_edge", {31'h0, Inst_Req_Valid}, 32'h1);
      wait_f(32'h108);
      F_ready = 1'b0;

      // 3a: backward BEQ (-8) predicted taken
      mem[32'h200] = 32'hFE00_0CE3;
      req_q.push_back(32'h200); req_q.push_back(32'h1F8);
      push_f(32'h200, 32'hFE00_0CE3, 1'b1, 32'h204);
      push_f(32'h1F8, NOP, 1'b0, 32'h1FC);
      redirect(32'h200);
      F_ready = 1'b1;
      wait_f(32'h1F8);
      F_ready = 1'b0;

      // 3b: forward BEQ (+16), JAL (+32), JALR
      mem[32'h200] = 32'h0000_0863;
      mem[32'h204] = 32'h0200_006F;
      mem[32'h228] = 32'h0000_8067;
      req_q.push_back(32'h200); req_q.push_back(32'h204); req_q.push_back(32'h224);
      req_q.push_back(32'h228); req_q.push_back(32'h22C);
      push_f(32'h200, 32'h0000_0863, 1'b0, 32'h210);
      push_f(32'h204, 32'h0200_006F, 1'b1, 32'h208);
      push_f(32'h224, NOP, 1'b0, 32'h228);
      push_f(32'h228, 32'h0000_8067, 1'b0, 32'h22C);
      push_f(32'h22C, NOP, 1'b0, 32'h230);
      redirect(32'h200);
      F_ready = 1'b1;
      wait_f(32'h22C);
      F_ready = 1'b0;

      // 4: redirect to 0x403 while waiting on a slow response
      mem[32'h300] = 32'hBAD0_0013;
      slow_addr  = 32'h300;
      slow_delay = 3;
      req_q.push_back(32'h300); req_q.push_back(32'h400);
      push_f(32'h400, NOP, 1'b0, 32'h404);
      redirect(32'h300);
      wait_ir();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h403;
      @(negedge clk);
      redirect_valid = 1'b0;
      wait_f(32'h400);

      // 5: hold with F_ready low, then redirect with F_ready in the same cycle
      repeat (4) @(negedge clk);
      req_q.push_back(32'hFFFF_FFFC); req_q.push_back(32'h0); req_q.push_back(32'h4);
      push_f(32'hFFFF_FFFC, NOP, 1'b0, 32'h0);
      push_f(32'h0, NOP, 1'b0, 32'h4);
      push_f(32'h4, NOP, 1'b0, 32'h8);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      F_ready        = 1'b1;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      chk("redir_hs_fvalid", {31'h0, F_valid}, 32'h0);
      chk("redir_hs_pc", PC, 32'hFFFF_FFFC);
      wait_f(32'h4);
      F_ready = 1'b0;

      // 6: asynchronous reset in the middle of a wait
      slow_addr  = 32'h500;
      slow_delay = 3;
      req_q.push_back(32'h500);
      redirect(32'h500);
      wait_ir();
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_inst_ready", {31'h0, Inst_Ready}, 32'h0);
      chk("async_rst_fpc", F_PC, 32'h0);
      chk("async_rst_finstr", F_instr, 32'h0);
      chk("async_rst_frecover", F_recoverPC, 32'h0);

      // 2: after reset, request stall of 5 cycles then a 3-cycle response delay
      mem[32'h104] = 32'h00A0_0093;
      stall_addr = 32'h104;
      stall_left = 5;
      slow_addr  = 32'h104;
      slow_delay = 3;
      req_q.push_back(32'h100); req_q.push_back(32'h104); req_q.push_back(32'h108);
      push_f(32'h100, NOP, 1'b0, 32'h104);
      push_f(32'h104, 32'h00A0_0093, 1'b0, 32'h108);
      push_f(32'h108, NOP, 1'b0, 32'h10C);
      F_ready = 1'b1;
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("refetch_pc", PC, 32'h100);
      wait_f(32'h108);
      F_ready = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk("req_queue_drained", req_q.size(), 32'h0);
      chk("f_queue_drained", f_q.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
